ahb_mem_slave: RTL and testbench

AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

---
 rtl/ahb_pkg.sv | 45 ++++
 rtl/ahb_mem_slave_if.sv | 34 +++
 rtl/ahb_mem_array.sv | 35 +++
 rtl/ahb_mem_slave.sv | 177 +++++++++++++++++
 tb/tb_ahb_mem_slave.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
//------------------------------------------------------------------------------
// Module      : ahb_pkg
// Description : Shared AHB encodings, response constants and slave FSM states.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    localparam logic c_HRESP_OKAY  = 1'b0;
    localparam logic c_HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    // NONSEQ and SEQ both have the upper encoding bit set
    function automatic logic f_is_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_mem_slave_if.sv
//------------------------------------------------------------------------------
// Module      : ahb_mem_slave_if
// Description : AHB bus bundle between a master and the memory slave.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ahb_mem_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   h_addr;
    logic [2:0]          h_burst;
    logic [2:0]          h_size;
    logic [1:0]          h_trans;
    logic [DATA_W-1:0]   h_wdata;
    logic [DATA_W/8-1:0] h_wstrb;
    logic                h_write;
    logic [DATA_W-1:0]   h_rdata;
    logic                h_ready;
    logic                h_resp;

    modport master (
        output h_addr, h_burst, h_size, h_trans, h_wdata, h_wstrb, h_write,
        input  h_rdata, h_ready, h_resp
    );

    modport slave (
        input  h_addr, h_burst, h_size, h_trans, h_wdata, h_wstrb, h_write,
        output h_rdata, h_ready, h_resp
    );
endinterface

`default_nettype wire

// File: rtl/ahb_mem_array.sv
//------------------------------------------------------------------------------
// Module      : ahb_mem_array
// Description : DEPTH x DATA_W storage, byte-enabled synchronous write,
//               asynchronous read.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ahb_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  wire logic                     clk,
    input  wire logic [DATA_W/8-1:0]      i_we,
    input  wire logic [$clog2(DEPTH)-1:0] i_addr,
    input  wire logic [DATA_W-1:0]        i_wdata,
    output logic      [DATA_W-1:0]        o_rdata
);
    localparam int c_BYTES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < c_BYTES; b++) begin
            if (i_we[b]) begin
                r_mem_q[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem_q[i_addr];

endmodule

`default_nettype wire

// File: rtl/ahb_mem_slave.sv
//------------------------------------------------------------------------------
// Module      : ahb_mem_slave
// Description : AHB memory slave with burst address tracking, programmable
//               wait states and two-cycle ERROR response.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  wire logic      h_clk,
    input  wire logic      h_reset,
    ahb_mem_slave_if.slave ahb
);
    localparam int               c_BYTES      = DATA_W / 8;
    localparam int               c_BYTES_LOG2 = $clog2(c_BYTES);
    localparam int               c_AW         = $clog2(DEPTH);
    localparam logic [2:0]       c_WAIT_LAST  = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [ADDR_W-1:0] c_ONE       = ADDR_W'(1);

    state_e              r_state_q,     w_state_d;
    logic [2:0]          r_wcnt_q,      w_wcnt_d;
    logic                r_dp_valid_q,  w_dp_valid_d;
    logic                r_dp_write_q,  w_dp_write_d;
    logic [c_AW-1:0]     r_dp_idx_q,    w_dp_idx_d;
    logic [c_BYTES-1:0]  r_dp_lanes_q,  w_dp_lanes_d;
    logic [ADDR_W-1:0]   r_next_addr_q, w_next_addr_d;
    logic [DATA_W-1:0]   r_rdata_q,     w_rdata_d;

    logic                    w_ready, w_resp, w_sample, w_err;
    logic                    w_bad_size, w_misaligned, w_out_of_range, w_seq_break;
    logic [c_BYTES_LOG2-1:0] w_off;
    logic [c_BYTES-1:0]      w_lanes, w_we;
    logic                    w_wr_done, w_rd_done;
    logic [DATA_W-1:0]       w_mem_rdata;

    // Address the next beat must carry; WRAP bursts fold inside their block
    function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] addr,
                                                      input logic [2:0]        burst,
                                                      input logic [2:0]        size);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] wrap_mask;
        step = c_ONE << size;
        case (burst)
            HBURST_WRAP4:  wrap_mask = (step << 2) - c_ONE;
            HBURST_WRAP8:  wrap_mask = (step << 3) - c_ONE;
            HBURST_WRAP16: wrap_mask = (step << 4) - c_ONE;
            default:       wrap_mask = '1;
        endcase
        return (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
    endfunction

    assign w_sample       = w_ready && f_is_active(ahb.h_trans);
    assign w_bad_size     = ahb.h_size > 3'(c_BYTES_LOG2);
    assign w_misaligned   = |(ahb.h_addr & ~({ADDR_W{1'b1}} << ahb.h_size));
    assign w_out_of_range = (ahb.h_addr >> c_BYTES_LOG2) >= ADDR_W'(DEPTH);
    assign w_seq_break    = (ahb.h_trans == HTRANS_SEQ) && (ahb.h_addr != r_next_addr_q);
    assign w_err          = w_bad_size || w_misaligned || w_out_of_range || w_seq_break;
    assign w_off          = ahb.h_addr[c_BYTES_LOG2-1:0];

    // A lane is selected when it shares the 2^size-byte chunk of the address
    always_comb begin
        w_lanes = '0;
        for (int b = 0; b < c_BYTES; b++) begin
            w_lanes[b] = ((b >> ahb.h_size) == (int'(w_off) >> ahb.h_size));
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_wcnt_d      = r_wcnt_q;
        w_dp_valid_d  = r_dp_valid_q;
        w_dp_write_d  = r_dp_write_q;
        w_dp_idx_d    = r_dp_idx_q;
        w_dp_lanes_d  = r_dp_lanes_q;
        w_next_addr_d = r_next_addr_q;
        w_ready       = 1'b1;
        w_resp        = c_HRESP_OKAY;

        case (r_state_q)
            ST_IDLE: begin
                w_dp_valid_d = 1'b0;
            end
            ST_WAIT: begin
                w_ready = 1'b0;
                if (r_wcnt_q == c_WAIT_LAST) begin
                    w_state_d = ST_IDLE;
                    w_wcnt_d  = 3'd0;
                end else begin
                    w_wcnt_d  = r_wcnt_q + 3'd1;
                end
            end
            ST_ERR1: begin
                w_ready   = 1'b0;
                w_resp    = c_HRESP_ERROR;
                w_state_d = ST_ERR2;
            end
            ST_ERR2: begin
                w_resp    = c_HRESP_ERROR;
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Pipelined address phase, accepted in any h_ready=1 cycle
        if (w_sample) begin
            w_next_addr_d = f_next_addr(ahb.h_addr, ahb.h_burst, ahb.h_size);
            w_dp_write_d  = ahb.h_write;
            w_dp_idx_d    = ahb.h_addr[c_BYTES_LOG2 +: c_AW];
            w_dp_lanes_d  = w_lanes;
            w_wcnt_d      = 3'd0;
            if (w_err) begin
                w_state_d    = ST_ERR1;
                w_dp_valid_d = 1'b0;
            end else if (WAIT_STATES == 0) begin
                w_state_d    = ST_IDLE;
                w_dp_valid_d = 1'b1;
            end else begin
                w_state_d    = ST_WAIT;
                w_dp_valid_d = 1'b1;
            end
        end
    end

    assign w_wr_done = (r_state_q == ST_IDLE) && r_dp_valid_q && r_dp_write_q && !h_reset;
    assign w_rd_done = (r_state_q == ST_IDLE) && r_dp_valid_q && !r_dp_write_q;
    assign w_we      = {c_BYTES{w_wr_done}} & ahb.h_wstrb & r_dp_lanes_q;
    assign w_rdata_d = w_rd_done ? w_mem_rdata : r_rdata_q;

    always_ff @(posedge h_clk) begin
        if (h_reset) begin
            r_state_q     <= ST_IDLE;
            r_wcnt_q      <= 3'd0;
            r_dp_valid_q  <= 1'b0;
            r_dp_write_q  <= 1'b0;
            r_dp_idx_q    <= '0;
            r_dp_lanes_q  <= '0;
            r_next_addr_q <= '0;
            r_rdata_q     <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_wcnt_q      <= w_wcnt_d;
            r_dp_valid_q  <= w_dp_valid_d;
            r_dp_write_q  <= w_dp_write_d;
            r_dp_idx_q    <= w_dp_idx_d;
            r_dp_lanes_q  <= w_dp_lanes_d;
            r_next_addr_q <= w_next_addr_d;
            r_rdata_q     <= w_rdata_d;
        end
    end

    ahb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (h_clk),
        .i_we    (w_we),
        .i_addr  (r_dp_idx_q),
        .i_wdata (ahb.h_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign ahb.h_ready = w_ready;
    assign ahb.h_resp  = w_resp;
    assign ahb.h_rdata = w_rdata_d;

endmodule

`default_nettype wire

// File: tb/tb_ahb_mem_slave.sv
//------------------------------------------------------------------------------
// Module      : tb_ahb_mem_slave
// Description : Scoreboard bench for ahb_mem_slave (DATA_W=32, DEPTH=64,
//               WAIT_STATES=1) driven by directed pipelined AHB transfers.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ahb_mem_slave;
    import ahb_pkg::*;

    localparam int c_WS = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) ahb ();

    ahb_mem_slave #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .DEPTH       (64),
        .WAIT_STATES (c_WS)
    ) dut (
        .h_clk   (clk),
        .h_reset (rst),
        .ahb     (ahb)
    );

    typedef struct {
        int          id;
        int          waits;
        logic        resp;
        logic        chk_rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_id     = 0;
    logic [31:0] last_rd  = '0;
    logic        mon_in_dp = 1'b0;
    int          mon_waits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts stall cycles of each data phase and checks it on completion
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_in_dp = 1'b0;
            end else begin
                if (mon_in_dp && !ahb.h_ready) begin
                    mon_waits++;
                    if (sb_q.size() > 0)
                        check($sformatf("t%0d resp while stalled", sb_q[0].id),
                              32'(ahb.h_resp), 32'(sb_q[0].resp));
                end else if (mon_in_dp) begin
                    mon_in_dp = 1'b0;
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected completion: got a data phase, expected none");
                    end else begin
                        e = sb_q.pop_front();
                        check($sformatf("t%0d wait cycles", e.id), 32'(mon_waits), 32'(e.waits));
                        check($sformatf("t%0d final resp", e.id), 32'(ahb.h_resp), 32'(e.resp));
                        if (e.chk_rd)
                            check($sformatf("t%0d rdata", e.id), ahb.h_rdata, e.rdata);
                    end
                end
                if (ahb.h_ready && ahb.h_trans[1]) begin
                    mon_in_dp = 1'b1;
                    mon_waits = 0;
                end
            end
        end
    end

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 32 && !ok; i++) begin
            @(negedge clk);
            ok = ahb.h_ready;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL h_ready timeout: h_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [2:0] burst, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic exp_err, input logic [31:0] exp_rd);
        exp_t e;
        ahb.h_trans = trans;
        ahb.h_write = wr;
        ahb.h_addr  = addr;
        ahb.h_size  = size;
        ahb.h_burst = burst;
        if (trans[1]) begin
            e.id     = n_id;
            n_id++;
            e.waits  = exp_err ? 1 : c_WS;
            e.resp   = exp_err;
            e.chk_rd = !wr;
            e.rdata  = exp_err ? last_rd : exp_rd;
            if (!wr && !exp_err) last_rd = exp_rd;
            sb_q.push_back(e);
        end
        wait_ready();
        if (trans[1]) begin
            ahb.h_wdata = wdata;
            ahb.h_wstrb = strb;
        end
    endtask

    task automatic wr(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] b, input logic err);
        beat(t, 1'b1, a, 3'd2, b, d, 4'hF, err, 32'h0);
    endtask

    task automatic rd(input logic [1:0] t, input logic [31:0] a, input logic [2:0] b,
                      input logic [31:0] exp, input logic err);
        beat(t, 1'b0, a, 3'd2, b, 32'h0, 4'h0, err, exp);
    endtask

    task automatic idle();
        ahb.h_trans = HTRANS_IDLE;
        wait_ready();
    endtask

    task automatic busy(input logic [31:0] a);
        ahb.h_trans = HTRANS_BUSY;
        ahb.h_addr  = a;
        wait_ready();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        ahb.h_trans = HTRANS_IDLE;
        ahb.h_addr  = '0;
        ahb.h_burst = HBURST_SINGLE;
        ahb.h_size  = 3'd2;
        ahb.h_write = 1'b0;
        ahb.h_wdata = '0;
        ahb.h_wstrb = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset h_ready", 32'(ahb.h_ready), 32'd1);
        check("reset h_resp", 32'(ahb.h_resp), 32'd0);
        check("reset h_rdata", ahb.h_rdata, 32'h0);
        @(posedge clk);
        #1;

        // Write then pipelined read of the same word
        wr(HTRANS_NONSEQ, 32'h10, 32'hDEADBEEF, HBURST_SINGLE, 1'b0);
        rd(HTRANS_NONSEQ, 32'h10, HBURST_SINGLE, 32'hDEADBEEF, 1'b0);
        idle();

        // Oversized transfer errors and leaves memory alone
        wr(HTRANS_NONSEQ, 32'h04, 32'h11223344, HBURST_SINGLE, 1'b0);
        beat(HTRANS_NONSEQ, 1'b1, 32'h04, 3'b110, HBURST_SINGLE, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
        rd(HTRANS_NONSEQ, 32'h04, HBURST_SINGLE, 32'h11223344, 1'b0);
        idle();

        // Out-of-range word, and the last valid word
        wr(HTRANS_NONSEQ, 32'h100, 32'h0BADF00D, HBURST_SINGLE, 1'b1);
        wr(HTRANS_NONSEQ, 32'hFC, 32'hC0FFEE63, HBURST_SINGLE, 1'b0);
        rd(HTRANS_NONSEQ, 32'hFC, HBURST_SINGLE, 32'hC0FFEE63, 1'b0);
        idle();

        // Byte write into lane 1 of word 0x10
        beat(HTRANS_NONSEQ, 1'b1, 32'h11, 3'd0, HBURST_SINGLE, 32'hAABBCCDD, 4'hF, 1'b0, 32'h0);
        rd(HTRANS_NONSEQ, 32'h10, HBURST_SINGLE, 32'hDEADCCEF, 1'b0);
        idle();

        // Misaligned read errors; h_rdata keeps the previous value
        rd(HTRANS_NONSEQ, 32'h02, HBURST_SINGLE, 32'h0, 1'b1);
        idle();

        // WRAP4 write with a BUSY after beat 2, read back as INCR4
        wr(HTRANS_NONSEQ, 32'h38, 32'h000000A0, HBURST_WRAP4, 1'b0);
        wr(HTRANS_SEQ,    32'h3C, 32'h000000A1, HBURST_WRAP4, 1'b0);
        busy(32'h30);
        wr(HTRANS_SEQ,    32'h30, 32'h000000A2, HBURST_WRAP4, 1'b0);
        wr(HTRANS_SEQ,    32'h34, 32'h000000A3, HBURST_WRAP4, 1'b0);
        idle();
        rd(HTRANS_NONSEQ, 32'h30, HBURST_INCR4, 32'h000000A2, 1'b0);
        rd(HTRANS_SEQ,    32'h34, HBURST_INCR4, 32'h000000A3, 1'b0);
        rd(HTRANS_SEQ,    32'h38, HBURST_INCR4, 32'h000000A0, 1'b0);
        rd(HTRANS_SEQ,    32'h3C, HBURST_INCR4, 32'h000000A1, 1'b0);
        idle();

        // INCR4 whose second beat skips to 0x08
        wr(HTRANS_NONSEQ, 32'h08, 32'h00000077, HBURST_SINGLE, 1'b0);
        wr(HTRANS_NONSEQ, 32'h00, 32'h00000055, HBURST_INCR4, 1'b0);
        wr(HTRANS_SEQ,    32'h08, 32'h00000066, HBURST_INCR4, 1'b1);
        idle();
        rd(HTRANS_NONSEQ, 32'h00, HBURST_SINGLE, 32'h00000055, 1'b0);
        rd(HTRANS_NONSEQ, 32'h08, HBURST_SINGLE, 32'h00000077, 1'b0);
        idle();

        // Reset while a write sits in its wait state
        wr(HTRANS_NONSEQ, 32'h20, 32'h12345678, HBURST_SINGLE, 1'b0);
        idle();
        ahb.h_trans = HTRANS_NONSEQ;
        ahb.h_write = 1'b1;
        ahb.h_addr  = 32'h20;
        ahb.h_size  = 3'd2;
        ahb.h_burst = HBURST_SINGLE;
        wait_ready();
        ahb.h_wdata = 32'hCAFEF00D;
        ahb.h_wstrb = 4'hF;
        ahb.h_trans = HTRANS_IDLE;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        last_rd = 32'h0;
        @(negedge clk);
        check("mid-wait reset h_ready", 32'(ahb.h_ready), 32'd1);
        check("mid-wait reset h_resp", 32'(ahb.h_resp), 32'd0);
        check("mid-wait reset h_rdata", ahb.h_rdata, 32'h0);
        @(posedge clk);
        #1;
        rd(HTRANS_NONSEQ, 32'h20, HBURST_SINGLE, 32'h12345678, 1'b0);
        idle();

        repeat (5) @(posedge clk);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
